aes_key_schedule_rev: RTL
=========================

Name: aes_key_schedule_rev

Overview:
- Iterative AES-128 round-key generator for the decryption datapath.
- Loads the cipher key, runs the expansion forward to round key nr, then emits round keys in reverse order (nr down to 0), one per handshake.
- It walks the key schedule the other direction, using the inverse recurrence, so no full expanded-key store is needed.
- Sits between key input and the iterative decrypt round engine; the engine consumes one round key per round.

Parameters:
- nk, 4, key length in 32-bit words; only 4 is supported, any other value is an elaboration error.
- nr, 10, number of rounds; only 10 is supported.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  [0:127]  cipher key, big-endian byte order (bit 0 = MSB of byte 0); sampled when key_load is accepted.
- key_load  input  1  start request; accepted only in IDLE.
- busy  output  1  high in any state except IDLE.
- rk_out  output  [0:127]  current round key, words w0..w3 from MSB end.
- rk_round  output  [3:0]  round index of rk_out.
- rk_valid  output  1  rk_out/rk_round valid.
- rk_ready  input  1  consumer accepts rk_out when rk_valid && rk_ready.
- done  output  1  one-cycle pulse after round-0 key is accepted.

Behaviour:
- Reset (async, any state): state=IDLE. busy=0, rk_valid=0, done=0, rk_out=0, rk_round=0, internal counters=0.
- States: IDLE, FWD, EMIT.
- IDLE:
  - On key_load=1: register key_in into the working key, set round counter=0, go to FWD.
  - key_load while busy is ignored; there is no abort.
- FWD: each cycle the round counter increments, and the working key (a0..a3) advances one round:
  - t = SubWord(RotWord(a3)) ^ Rcon(cnt+1)
  - n0 = a0^t, n1 = a1^n0, n2 = a2^n1, n3 = a3^n2
  - After nr steps (cnt=nr), go to EMIT.
- EMIT:
  - rk_valid=1, rk_out=working key, rk_round=cnt.
  - First rk_valid=1 is visible nr+1 rising edges after the edge that sampled key_load.
  - On valid&&ready with cnt>0: step back one round and decrement cnt. Next cycle shows round cnt-1; rk_valid stays high, giving one key per cycle with ready held high. Inverse step:
    - p3 = a3^a2, p2 = a2^a1, p1 = a1^a0
    - p0 = a0 ^ SubWord(RotWord(p3)) ^ Rcon(cnt)
  - On valid&&ready with cnt=0: go to IDLE. Next cycle: rk_valid=0, done=1 for one cycle.
  - rk_ready low: rk_out, rk_round and rk_valid hold stable; no change until accepted.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the MS byte, zero elsewhere. Any other index yields 0.
- A new key_load may be presented in the cycle done is high; it is accepted because the state is IDLE.
- Reset mid-FWD or mid-EMIT: immediate return to reset values. No key is emitted afterwards until a new load.

Optional Feature:
- Macro: AES_KEYREV_CACHE_EN.
- Defined:
  - Block keeps a 128-bit tag of the last fully-expanded key_in and the round-nr key.
  - key_load with key_in equal to the tag skips FWD. EMIT starts with round nr, first rk_valid one edge after load.
  - Tag is cleared by rst.
  - A load with a different key overwrites the tag when FWD completes.
- Undefined: every load runs FWD (nr cycles); no tag registers exist.

Decomposition:
- Shared package aes_pkg:
  - Rcon table as a function of round index.
  - NB=4 constant.
  - State enum encodings IDLE/FWD/EMIT.
  - RotWord and word-XOR helpers.
- One sub-module aes_sbox: combinational 8-bit S-box lookup.
  - Four instances form SubWord.
  - Input is muxed between a3 (FWD) and p3 (EMIT); the S-box is shared by both directions.

Test Plan:
- FIPS-197 load: key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> exactly 11 edges after load, rk_valid=1, rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6. Next 10 cycles give rounds 9..0, with round 1 = a0fafe1788542cb123a339392a6c7605 and round 0 = key_in. done pulses once, busy drops.
- Backpressure: same key, rk_ready toggled randomly -> rk_out/rk_round stable while ready=0; sequence 10..0 identical to the previous case; no round skipped or duplicated.
- Ignored load: key_load pulsed with a different key during FWD and during EMIT -> output sequence unchanged from the first key.
- Async reset: assert rst mid-EMIT at round 5 -> rk_valid, busy, done and rk_out go to 0 without a clock edge. Subsequent load of an all-zero key -> round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back: load a second key in the done cycle -> accepted; its round-10 key appears 11 edges later.
- Cache build (AES_KEYREV_CACHE_EN): reload the FIPS-197 key -> rk_valid with round 10 one edge after load. Load a different key -> full 11-edge latency.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the reverse AES-128 key schedule.
// Holds the FSM encoding, the Rcon table and word-level helpers.
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Round constant in the MS byte; any index outside 1..10 yields 0.
  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h0};
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] xw(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a ^ b;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// The table is packed MSB-first so byte n sits at bits 8n..8n+7.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Pure table lookup.
  always_comb y = TBL[{a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule_rev.sv
// AES-128 round keys for decryption: expand forward, emit nr..0.
// Define AES_KEYREV_CACHE_EN to cache the last expanded key.
module aes_key_schedule_rev
  import aes_pkg::*;
#(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  if (nk != NB || nr != 10) begin : g_bad
    $error("aes_key_schedule_rev: only nk=4, nr=10");
  end

  localparam logic [3:0] NRL = 4'(nr);

  state_t       state, nstate;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [127:0] kin;

  logic [31:0] a0, a1, a2, a3;
  logic [31:0] p1, p2, p3;
  logic [31:0] rw, sw, t;
  logic [127:0] fwd_key, inv_key;

  assign kin = key_in;
  assign {a0, a1, a2, a3} = key_q;

  assign p3 = xw(a3, a2);
  assign p2 = xw(a2, a1);
  assign p1 = xw(a1, a0);

  assign rw = rot_word(state == EMIT ? p3 : a3);

  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (
      .a (rw[8*i +: 8]),
      .y (sw[8*i +: 8])
    );
  end

  assign t = xw(sw, rcon(cnt_q + 4'd1));

  // One forward round of the recurrence, chained word to word.
  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0 = xw(a0, t);
    n1 = xw(a1, n0);
    n2 = xw(a2, n1);
    n3 = xw(a3, n2);
    fwd_key = {n0, n1, n2, n3};
  end

  // One backward round: recover the previous round's four words.
  always_comb begin
    logic [31:0] p0;
    p0 = xw(xw(a0, sw), rcon(cnt_q));
    inv_key = {p0, p1, p2, p3};
  end

`ifdef AES_KEYREV_CACHE_EN
  logic [127:0] tag_q, tag_d, trk_q, trk_d;
  logic [127:0] pend_q, pend_d;
  logic         tv_q, tv_d;
  logic         hit;

  assign hit = tv_q && (kin == tag_q);
`endif

  // Next-state, working key and counter.
  always_comb begin
    nstate = state;
    key_d  = key_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
`ifdef AES_KEYREV_CACHE_EN
    tag_d  = tag_q;
    trk_d  = trk_q;
    pend_d = pend_q;
    tv_d   = tv_q;
`endif
    unique case (state)
      IDLE: begin
        if (key_load) begin
          key_d  = kin;
          cnt_d  = 4'd0;
          nstate = FWD;
`ifdef AES_KEYREV_CACHE_EN
          pend_d = kin;
          if (hit) begin
            key_d  = trk_q;
            cnt_d  = NRL;
            nstate = EMIT;
          end
`endif
        end
      end
      FWD: begin
        if (cnt_q == NRL) begin
          nstate = EMIT;
`ifdef AES_KEYREV_CACHE_EN
          tag_d = pend_q;
          trk_d = key_q;
          tv_d  = 1'b1;
`endif
        end else begin
          key_d = fwd_key;
          cnt_d = cnt_q + 4'd1;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (cnt_q == 4'd0) begin
            nstate = IDLE;
            done_d = 1'b1;
          end else begin
            key_d = inv_key;
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // State, working key, counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      key_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      key_q  <= key_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef AES_KEYREV_CACHE_EN
  // Tag of the last completed expansion and its round-nr key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= '0;
      trk_q  <= '0;
      pend_q <= '0;
      tv_q   <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      trk_q  <= trk_d;
      pend_q <= pend_d;
      tv_q   <= tv_d;
    end
  end
`endif

  // Outputs are zero outside EMIT so reset clears them at once.
  always_comb begin
    busy     = (state != IDLE);
    rk_valid = (state == EMIT);
    rk_out   = rk_valid ? key_q : '0;
    rk_round = rk_valid ? cnt_q : 4'd0;
    done     = done_q;
  end

endmodule
